lfsr_encrypt_ctrl: RTL

Sequencer that runs the padded-LFSR encryption job against the data memory.
- Reads the three operand bytes and the 52-char plaintext over the memory's combinational read port.
- Writes the 64-byte padded, encrypted message through the memory's clocked write port.
- Sits directly upstream of the memory write side and downstream of its read side; one start/done handshake to the testbench/top.

---
 rtl/lfsr_enc_pkg.sv | 22 ++
 rtl/lfsr_step.sv | 17 +
 rtl/lfsr_encrypt_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/lfsr_enc_pkg.sv
// Shared constants and state encoding for the padded-LFSR encryption sequencer
// and the matching decrypt block.
package lfsr_enc_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t LD_PRE  = 3'd1;
    localparam state_t LD_TAP  = 3'd2;
    localparam state_t LD_SEED = 3'd3;
    localparam state_t RUN     = 3'd4;
    localparam state_t DONE    = 3'd5;

    localparam int unsigned LFSR_W   = 5;
    localparam int unsigned MSG_BASE = 4;
    localparam int unsigned MSG_LEN  = 52;
    localparam int unsigned OUT_BASE = 128;
    localparam int unsigned OUT_LEN  = 64;
    localparam int unsigned PRE_MAX  = 12;
    localparam logic [7:0]  PAD_CHAR = 8'h20;

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR step: shift left, feed back the parity of the
// tapped bits into bit 0.
module lfsr_step
    import lfsr_enc_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_W
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = {cur[WIDTH-2:0], ^(cur & taps)};
    end

endmodule

// File: rtl/lfsr_encrypt_ctrl.sv
// Sequencer: loads preamble/taps/seed from memory, then writes the 64-byte
// padded plaintext XORed with the LFSR keystream, one byte per cycle.
module lfsr_encrypt_ctrl
    import lfsr_enc_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] raddr,
    input  logic [W-1:0]      rdata,
    output logic [ADDR_W-1:0] waddr,
    output logic [W-1:0]      wdata,
    output logic              write_en
);

    state_t            state;
    logic [5:0]        idx;
    logic [3:0]        pre;
    logic [LFSR_W-1:0] taps;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [6:0]        rel;
    logic [W-1:0]      pt;

    lfsr_step #(.WIDTH(LFSR_W)) u_step (
        .cur  (lfsr),
        .taps (taps),
        .nxt  (lfsr_nxt)
    );

    assign busy = (state == LD_PRE) || (state == LD_TAP) ||
                  (state == LD_SEED) || (state == RUN);
    assign done = (state == DONE);

    // Offset into the plaintext; only meaningful once idx has passed the preamble.
    assign rel = 7'(idx) - 7'(pre);

    always_comb begin
        raddr    = '0;
        waddr    = '0;
        wdata    = '0;
        write_en = 1'b0;
        pt       = W'(PAD_CHAR);
        case (state)
            LD_PRE:  raddr = ADDR_W'(0);
            LD_TAP:  raddr = ADDR_W'(1);
            LD_SEED: raddr = ADDR_W'(2);
            RUN: begin
                if ((idx >= 6'(pre)) && (rel < 7'(MSG_LEN))) begin
                    raddr = ADDR_W'(MSG_BASE) + ADDR_W'(rel);
                    pt    = rdata;
                end
                write_en = 1'b1;
                waddr    = ADDR_W'(OUT_BASE) + ADDR_W'(idx);
                wdata    = pt ^ W'(lfsr);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            pre   <= '0;
            taps  <= '0;
            lfsr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LD_PRE;
                end
                LD_PRE: begin
                    pre   <= (rdata > W'(PRE_MAX)) ? 4'(PRE_MAX) : rdata[3:0];
                    state <= LD_TAP;
                end
                LD_TAP: begin
                    taps  <= rdata[LFSR_W-1:0];
                    state <= LD_SEED;
                end
                LD_SEED: begin
                    lfsr  <= rdata[LFSR_W-1:0];
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    lfsr <= lfsr_nxt;
                    idx  <= idx + 6'd1;
                    if (idx == 6'(OUT_LEN - 1)) state <= DONE;
                end
                DONE: begin
                    if (!start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
